// File: rtl/maxnet_mem_loader_pkg.sv
// maxnet_mem_loader_pkg: shared sizes and loader state encodings for the Maxnet operand memory
package maxnet_mem_loader_pkg;
  localparam int DATA_W = 5;
  localparam int N = 4;
  localparam int TOTAL_WORDS = N + N * N;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD_X = 2'd1;
  localparam logic [1:0] LOAD_W = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/maxnet_mem_loader_reg.sv
// maxnet_mem_loader_reg: parameterised storage register with load enable
module maxnet_mem_loader_reg #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (!rst) q <= '0;
    else if (ld) q <= d;
endmodule

// File: rtl/maxnet_mem_loader.sv
// maxnet_mem_loader: streams X then W words into registers and flags a resident operand set
module maxnet_mem_loader #(
  parameter int DATA_W = maxnet_mem_loader_pkg::DATA_W,
  parameter int N = maxnet_mem_loader_pkg::N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [N*DATA_W-1:0]   x_flat,
  output logic [N*N*DATA_W-1:0] w_flat,
  output logic                  mem_valid,
  output logic                  load_done,
  output logic [4:0]            word_cnt
);
  import maxnet_mem_loader_pkg::*;
  localparam int TOTAL = N + N * N;
  logic [1:0] state;
  logic [TOTAL*DATA_W-1:0] mem;
  logic xfer;
  assign in_ready = state == LOAD_X || state == LOAD_W;
  assign mem_valid = state == DONE;
  // start wins over a word presented in the same cycle
  assign xfer = in_valid && in_ready && !start;
  assign x_flat = mem[N*DATA_W-1:0];
  assign w_flat = mem[TOTAL*DATA_W-1:N*DATA_W];
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      word_cnt <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= xfer && word_cnt == 5'(TOTAL - 1);
      if (start) begin
        state <= LOAD_X;
        word_cnt <= '0;
      end else if (xfer) begin
        word_cnt <= word_cnt + 5'd1;
        if (word_cnt == 5'(N - 1)) state <= LOAD_W;
        if (word_cnt == 5'(TOTAL - 1)) state <= DONE;
      end
    end
  for (genvar k = 0; k < TOTAL; k++) begin : g_word
    maxnet_mem_loader_reg #(.W(DATA_W)) u_reg (
      .clk(clk),
      .rst(rst),
      .ld(xfer && word_cnt == 5'(k)),
      .d(in_data),
      .q(mem[k*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_maxnet_mem_loader.sv
// tb_maxnet_mem_loader: scoreboard bench for the Maxnet operand loader
module tb_maxnet_mem_loader;
  localparam int DW = 5;
  localparam int NN = 4;
  localparam int TOT = NN + NN * NN;
  logic clk = 0, rst = 0, start = 0, in_valid = 0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, mem_valid, load_done;
  logic [NN*DW-1:0] x_flat;
  logic [NN*NN*DW-1:0] w_flat;
  logic [4:0] word_cnt;
  typedef struct {int idx; logic [DW-1:0] val;} ent_t;
  ent_t sb[$];
  logic [DW-1:0] exp_mem [TOT];
  logic [NN*DW-1:0] seq_x;
  logic [NN*NN*DW-1:0] seq_w;
  int bcnt = 0;
  bit loading = 0, mvalid = 0, exp_done = 0;
  int checks = 0, errors = 0;

  maxnet_mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .x_flat(x_flat), .w_flat(w_flat), .mem_valid(mem_valid),
    .load_done(load_done), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // one clock: update the reference model, then compare every word written on that edge
  task automatic tick();
    ent_t e;
    logic [DW-1:0] got;
    @(posedge clk);
    exp_done = 0;
    if (!rst) begin
      foreach (exp_mem[i]) exp_mem[i] = '0;
      bcnt = 0; loading = 0; mvalid = 0;
      sb.delete();
    end else if (start) begin
      loading = 1; bcnt = 0; mvalid = 0;
    end else if (in_valid && loading) begin
      sb.push_back('{bcnt, in_data});
      exp_mem[bcnt] = in_data;
      bcnt++;
      if (bcnt == TOT) begin loading = 0; mvalid = 1; exp_done = 1; end
    end
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = e.idx < NN ? x_flat[e.idx*DW +: DW] : w_flat[(e.idx-NN)*DW +: DW];
      checks++;
      if (got !== e.val) begin errors++; $display("FAIL word%0d got %h expected %h", e.idx, got, e.val); end
    end
    checks++;
    if (word_cnt !== 5'(bcnt)) begin errors++; $display("FAIL word_cnt got %0d expected %0d", word_cnt, bcnt); end
    checks++;
    if (in_ready !== loading) begin errors++; $display("FAIL in_ready got %b expected %b", in_ready, loading); end
    checks++;
    if (mem_valid !== mvalid) begin errors++; $display("FAIL mem_valid got %b expected %b", mem_valid, mvalid); end
    checks++;
    if (load_done !== exp_done) begin errors++; $display("FAIL load_done got %b expected %b", load_done, exp_done); end
  endtask

  // drives n words (optionally with an idle cycle between words); reports the tick load_done was seen on
  task automatic send(input int n, input bit stall, input bit fixed, input logic [DW-1:0] fv, output int done_at);
    int t = 0;
    done_at = 0;
    for (int i = 0; i < n; i++) begin
      if (stall && i > 0) begin
        in_valid = 0; in_data = 5'h1F; tick(); t++;
        if (load_done === 1'b1 && done_at == 0) done_at = t;
      end
      in_valid = 1; in_data = fixed ? fv : 5'(i + 1);
      tick(); t++;
      if (load_done === 1'b1 && done_at == 0) done_at = t;
    end
    in_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic test_reset();
    rst = 0; tick(); tick();
    rst = 1; in_valid = 1; in_data = 5'h1F;
    tick(); tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
    checks++;
    if (x_flat !== '0 || w_flat !== '0) begin errors++; $display("FAIL reset_storage got x=%h w=%h expected 0", x_flat, w_flat); end
    checks++;
    if (word_cnt !== 5'd0 || mem_valid !== 1'b0) begin errors++; $display("FAIL reset_status got cnt=%0d mv=%b expected 0/0", word_cnt, mem_valid); end
    in_valid = 0;
  endtask

  task automatic test_full_load();
    int d;
    pulse_start();
    send(TOT, 0, 0, '0, d);
    checks++;
    if (d !== TOT) begin errors++; $display("FAIL full_done_time got %0d expected %0d", d, TOT); end
    checks++;
    if (x_flat[4:0] !== 5'd1 || w_flat[79:75] !== 5'd20) begin errors++; $display("FAIL full_corners got %h/%h expected 01/14", x_flat[4:0], w_flat[79:75]); end
    checks++;
    if (x_flat !== seq_x || w_flat !== seq_w) begin errors++; $display("FAIL full_contents got x=%h w=%h expected x=%h w=%h", x_flat, w_flat, seq_x, seq_w); end
    tick(); tick();
    checks++;
    if (mem_valid !== 1'b1 || word_cnt !== 5'd20 || load_done !== 1'b0) begin errors++; $display("FAIL full_hold got mv=%b cnt=%0d ld=%b expected 1/20/0", mem_valid, word_cnt, load_done); end
  endtask

  task automatic test_stalls();
    int d;
    pulse_start();
    send(TOT, 1, 0, '0, d);
    checks++;
    if (d !== 39) begin errors++; $display("FAIL stall_done_time got %0d expected 39", d); end
    checks++;
    if (x_flat !== seq_x || w_flat !== seq_w) begin errors++; $display("FAIL stall_contents got x=%h w=%h expected x=%h w=%h", x_flat, w_flat, seq_x, seq_w); end
  endtask

  task automatic test_restart();
    int d;
    pulse_start();
    send(7, 0, 1, 5'h11, d);
    start = 1; in_valid = 1; in_data = 5'h0A;
    tick();
    start = 0; in_valid = 0;
    checks++;
    if (word_cnt !== 5'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL restart_state got cnt=%0d rdy=%b expected 0/1", word_cnt, in_ready); end
    checks++;
    if (w_flat[19:15] !== 5'd8) begin errors++; $display("FAIL restart_nowrite got %h expected 08", w_flat[19:15]); end
    send(TOT, 0, 0, '0, d);
    checks++;
    if (d !== TOT || x_flat !== seq_x || w_flat !== seq_w) begin errors++; $display("FAIL restart_reload got done=%0d x=%h w=%h", d, x_flat, w_flat); end
  endtask

  task automatic test_reload();
    int d;
    pulse_start();
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("FAIL reload_mv_drop got %b expected 0", mem_valid); end
    send(TOT, 0, 1, 5'h03, d);
    checks++;
    if (d !== TOT) begin errors++; $display("FAIL reload_done_time got %0d expected %0d", d, TOT); end
    checks++;
    if (x_flat !== {NN{5'h03}} || w_flat !== {NN*NN{5'h03}}) begin errors++; $display("FAIL reload_contents got x=%h w=%h", x_flat, w_flat); end
  endtask

  task automatic test_reset_mid();
    int d;
    pulse_start();
    send(12, 0, 0, '0, d);
    rst = 0; in_valid = 1; in_data = 5'h15;
    tick();
    rst = 1;
    checks++;
    if (x_flat !== '0 || w_flat !== '0) begin errors++; $display("FAIL midreset_storage got x=%h w=%h expected 0", x_flat, w_flat); end
    checks++;
    if (in_ready !== 1'b0 || word_cnt !== 5'd0 || mem_valid !== 1'b0) begin errors++; $display("FAIL midreset_state got rdy=%b cnt=%0d mv=%b", in_ready, word_cnt, mem_valid); end
    d = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (load_done === 1'b1) d++;
    end
    checks++;
    if (d !== 0) begin errors++; $display("FAIL midreset_no_done got %0d pulses expected 0", d); end
    in_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < NN; i++) seq_x[i*DW +: DW] = 5'(i + 1);
    for (int i = 0; i < NN * NN; i++) seq_w[i*DW +: DW] = 5'(i + NN + 1);
    test_reset();
    test_full_load();
    test_stalls();
    test_restart();
    test_reload();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/maxnet_mem_loader.md
Name: maxnet_mem_loader

Overview:
- Writer side of the Maxnet operand memory: receives input activations X and weights W as a stream of words over a valid/ready handshake.
- Stores the words in an internal register file and presents them as flat parallel buses to the Maxnet datapath.
- Signals the controller when a complete operand set is resident.
- Replaces the fixed-content memory whenever operands must change at run time.

Parameters:
- DATA_W, 5, width of each activation/weight word.
- N, 4, number of neurons; the block stores N X words and N*N W words.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; clears the word counter and begins a new load.
- in_valid  input  1  in_data carries a word.
- in_data  input  DATA_W  stream word.
- in_ready  output  1  block accepts a word this cycle.
- x_flat  output  N*DATA_W  X[i] at bits [i*DATA_W +: DATA_W].
- w_flat  output  N*N*DATA_W  W[k] at bits [k*DATA_W +: DATA_W]; k = row*N+col; PU j uses W[j*N .. j*N+N-1].
- mem_valid  output  1  level; a complete operand set is stored.
- load_done  output  1  one-cycle pulse on the cycle mem_valid rises.
- word_cnt  output  5  number of words accepted in the current load, 0..N+N*N.

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=IDLE; word_cnt=0; all X and W registers 0.
  - in_ready=0, mem_valid=0, load_done=0.
  - Reset mid-load discards the partial set.
- States: IDLE, LOAD_X, LOAD_W, DONE.
- IDLE: in_ready=0; in_valid is ignored. start -> LOAD_X with word_cnt=0.
- LOAD_X:
  - in_ready=1; a transfer occurs when in_valid&&in_ready.
  - Each transfer writes X[word_cnt] and increments word_cnt.
  - The transfer with word_cnt==N-1 moves to LOAD_W.
- LOAD_W:
  - in_ready=1; each transfer writes W[word_cnt-N] and increments word_cnt.
  - The transfer with word_cnt==N+N*N-1 moves to DONE.
- DONE:
  - in_ready=0; mem_valid=1.
  - load_done=1 only on the first cycle in DONE. Registered, so it appears the cycle after the last transfer.
  - The stored set holds indefinitely.
  - start -> LOAD_X with word_cnt=0; mem_valid drops the next cycle.
- Stream order: X[0..N-1], then W[0..N*N-1]. With default parameters that is 20 words, and word_cnt reaches 20.
- Storage writes take effect the cycle after the transfer. x_flat/w_flat are driven directly from the registers, with no extra output latency.
- Registers not yet overwritten in a new load keep their previous values. Consumers rely only on mem_valid.
- start during LOAD_X/LOAD_W:
  - Restarts at LOAD_X with word_cnt=0.
  - A word presented in that same cycle is not written; start has priority.
- in_valid low stalls without side effects. Back-to-back transfers every cycle are supported (full throughput).
- No arithmetic on data; words are stored unsigned/as-is.
- word_cnt never exceeds N+N*N; no wrap-around.

Decomposition:
- Shared package/header: DATA_W, N, derived TOTAL_WORDS=N+N*N, and state encodings IDLE/LOAD_X/LOAD_W/DONE. These are reused by the Maxnet controller.
- One natural sub-module: the existing parameterised register (with ld) for each storage word. Instantiate it N+N*N times via generate, with the write enable decoded from word_cnt.

Test Plan:
- Reset then idle: rst=0 two cycles, then in_valid=1, in_data=5'h1F with no start -> in_ready=0, mem_valid=0, x_flat=0, w_flat=0, word_cnt=0.
- Full load, no stalls: start, then 20 words value=index+1 on consecutive cycles:
  - X=1..4, W[0]=5..W[15]=20.
  - load_done pulses exactly one cycle after word 20; mem_valid=1; word_cnt=20.
  - x_flat[4:0]=1; w_flat[79:75]=20.
- Stalls: same load with in_valid toggling 1/0 every cycle -> identical final contents; word_cnt advances only on valid cycles; load_done after 39 cycles.
- Restart mid-load: after 7 words, assert start with in_valid=1, in_data=5'h0A -> word not stored, word_cnt=0, state LOAD_X. Next 20 words load correctly.
- Reload from DONE: after a full load, start -> mem_valid=0 the next cycle. A new 20-word set of all 5'h03 replaces the contents; load_done pulses again.
- Reset mid-load: rst=0 after 12 words -> all storage 0, state IDLE, in_ready=0, and no load_done pulse.
